mem_arbiter: RTL and testbench

Memory-side responder for the cache bus: accepts instruction and data requests from up to `CPUS` cache blocks and serializes them onto the single-port RAM. Responses are returned through per-core `iwait`/`dwait` and `iload`/`dload`. It sits between the cache blocks and the RAM and replaces the combinational memory control. All RAM accesses are registered, and arbitration is fair across cores.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: fair round-robin arbiter serializing per-core instruction/data requests onto a single-port RAM
module mem_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  iaddr,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  iload,
  output logic [CPUS-1:0][31:0]  dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic [1:0]             ramstate
);
  localparam int IW = CPUS > 1 ? $clog2(CPUS) : 1;
  localparam logic [IW:0] NC = (IW+1)'(CPUS);
  localparam logic [IW-1:0] LAST = IW'(CPUS - 1);
  localparam logic [1:0] ACCESS = 2'd2;
  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, iptr, iptr_n, dptr, dptr_n, ipick, dpick, nxt;
  logic [IW:0] dsum, isum;
  logic wr, wr_n, dfound, ifound, dheld;
  logic [31:0] addr_r, addr_n, store_r, store_n;
  logic [CPUS-1:0] dreq;
  assign dreq = dREN | dWEN;
  assign nxt = owner == LAST ? '0 : owner + 1'b1;
  assign dheld = wr ? dWEN[owner] : dREN[owner];
  assign ramREN = state == INSTR || (state == DATA && !wr);
  assign ramWEN = state == DATA && wr;
  assign ramaddr = addr_r;
  assign ramstore = store_r;
  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};
  // round-robin search upward from each class pointer with wrap-around
  always_comb begin
    dpick = dptr;
    ipick = iptr;
    dfound = 1'b0;
    ifound = 1'b0;
    dsum = '0;
    isum = '0;
    for (int i = 0; i < CPUS; i++) begin
      dsum = {1'b0, dptr} + (IW+1)'(i);
      isum = {1'b0, iptr} + (IW+1)'(i);
      dsum = dsum >= NC ? dsum - NC : dsum;
      isum = isum >= NC ? isum - NC : isum;
      if (!dfound && dreq[dsum[IW-1:0]]) begin
        dfound = 1'b1;
        dpick = dsum[IW-1:0];
      end
      if (!ifound && iREN[isum[IW-1:0]]) begin
        ifound = 1'b1;
        ipick = isum[IW-1:0];
      end
    end
  end
  // next-state, grant latching and per-core wait release
  always_comb begin
    state_n = state;
    owner_n = owner;
    wr_n = wr;
    addr_n = addr_r;
    store_n = store_r;
    iptr_n = iptr;
    dptr_n = dptr;
    iwait = '1;
    dwait = '1;
    case (state)
      IDLE: begin
        if (dfound) begin
          state_n = DATA;
          owner_n = dpick;
          wr_n = dWEN[dpick];
          addr_n = daddr[dpick];
          store_n = dstore[dpick];
        end else if (ifound) begin
          state_n = INSTR;
          owner_n = ipick;
          wr_n = 1'b0;
          addr_n = iaddr[ipick];
          store_n = '0;
        end
      end
      DATA: begin
        if (!dheld) state_n = IDLE;
        else if (ramstate == ACCESS) begin
          dwait[owner] = 1'b0;
          dptr_n = nxt;
          state_n = IDLE;
        end
      end
      INSTR: begin
        if (!iREN[owner]) state_n = IDLE;
        else if (ramstate == ACCESS) begin
          iwait[owner] = 1'b0;
          iptr_n = nxt;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state, owner and RAM-facing registers; reset clears any in-flight access
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      wr <= 1'b0;
      addr_r <= '0;
      store_r <= '0;
      iptr <= '0;
      dptr <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      wr <= wr_n;
      addr_r <= addr_n;
      store_r <= store_n;
      iptr <= iptr_n;
      dptr <= dptr_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
  localparam int CPUS = 2;
  localparam logic [1:0] F = 2'd0, B = 2'd1, A = 2'd2, E = 2'd3;
  logic CLK = 1'b0;
  logic nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore, iload, dload;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  int vectors = 0;
  int miscompares = 0;
  always #5 CLK = ~CLK;
  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );
  typedef struct {
    logic [1:0] iren, dren, dwen, rs;
    logic [31:0] da1;
    logic ren, wen;
    logic [31:0] addr, store;
    logic [1:0] iw, dw;
  } vec_t;
  vec_t tbl[$];
  bit act = 0, isd = 0, isw = 0;
  int own = 0, ip = 0, dp = 0;
  logic [31:0] ma, ms;
  logic [31:0] mem [16];
  bit dpend [CPUS], dwr [CPUS], dboth [CPUS], ipend [CPUS];
  logic [31:0] dad [CPUS], dst [CPUS], iad [CPUS];
  function automatic vec_t mk(input logic [1:0] iren, dren, dwen, rs, input logic [31:0] da1,
                              input logic ren, wen, input logic [31:0] addr, store,
                              input logic [1:0] iw, dw);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.da1 = da1;
    v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.iw = iw; v.dw = dw;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask
  task automatic step(input int r, input vec_t v);
    iREN = v.iren; dREN = v.dren; dWEN = v.dwen; ramstate = v.rs; daddr[1] = v.da1;
    #1;
    chk($sformatf("row%0d ramREN", r), 32'(ramREN), 32'(v.ren));
    chk($sformatf("row%0d ramWEN", r), 32'(ramWEN), 32'(v.wen));
    chk($sformatf("row%0d iwait", r), 32'(iwait), 32'(v.iw));
    chk($sformatf("row%0d dwait", r), 32'(dwait), 32'(v.dw));
    if (v.ren || v.wen) chk($sformatf("row%0d ramaddr", r), ramaddr, v.addr);
    if (v.wen) chk($sformatf("row%0d ramstore", r), ramstore, v.store);
    for (int c = 0; c < CPUS; c++) begin
      if (!v.iw[c]) chk($sformatf("row%0d iload%0d", r, c), iload[c], 32'hDEADBEEF);
      if (!v.dw[c]) chk($sformatf("row%0d dload%0d", r, c), dload[c], 32'hDEADBEEF);
    end
    @(posedge CLK); #1;
  endtask
  task automatic model_edge();
    bit held;
    int c;
    if (act) begin
      held = isd ? (isw ? dWEN[own] : dREN[own]) : iREN[own];
      if (!held) act = 0;
      else if (ramstate == A) begin
        if (isd && isw) mem[ma[5:2]] = ms;
        if (isd) begin dp = (own + 1) % CPUS; dpend[own] = 0; end
        else begin ip = (own + 1) % CPUS; ipend[own] = 0; end
        act = 0;
      end
    end else begin
      for (int i = 0; i < CPUS && !act; i++) begin
        c = (dp + i) % CPUS;
        if (dpend[c]) begin act = 1; own = c; isd = 1; isw = dwr[c]; ma = dad[c]; ms = dst[c]; end
      end
      for (int i = 0; i < CPUS && !act; i++) begin
        c = (ip + i) % CPUS;
        if (ipend[c]) begin act = 1; own = c; isd = 0; isw = 0; ma = iad[c]; ms = '0; end
      end
    end
  endtask
  initial begin
    logic [1:0] iwx, dwx;
    bit rel;
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = F; ramload = 32'hDEADBEEF;
    iaddr[0] = 32'h40; iaddr[1] = 32'h80; daddr[0] = 32'h10; daddr[1] = 32'h100;
    dstore[0] = 32'h5555; dstore[1] = 32'h1234;
    // single fetch, data beats instruction, round-robin, error retry, abort
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, F, 32'h100, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, B, 32'h100, 1, 0, 32'h40, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, A, 32'h100, 1, 0, 32'h40, 0, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 32'h100, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b01, 2'b00, 2'b10, F, 32'h100, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b01, 2'b00, 2'b10, A, 32'h100, 0, 1, 32'h100, 32'h1234, 2'b11, 2'b01));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, F, 32'h100, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, A, 32'h100, 1, 0, 32'h40, 0, 2'b10, 2'b11));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 32'h100, 0, 0, 0, 0, 2'b11, 2'b11));
    for (int k = 0; k < 4; k++) begin
      tbl.push_back(mk(2'b00, 2'b11, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
      tbl.push_back(mk(2'b00, 2'b11, 2'b00, A, 32'h20, 1, 0, k % 2 ? 32'h20 : 32'h10, 0,
                       2'b11, k % 2 ? 2'b01 : 2'b10));
    end
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(2'b00, 2'b01, 2'b00, E, 32'h20, 1, 0, 32'h10, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, A, 32'h20, 1, 0, 32'h10, 0, 2'b11, 2'b10));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b10, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b10, 2'b00, A, 32'h20, 1, 0, 32'h20, 0, 2'b11, 2'b01));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, B, 32'h20, 1, 0, 32'h10, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, B, 32'h20, 1, 0, 32'h10, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b11, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    tbl.push_back(mk(2'b00, 2'b11, 2'b00, A, 32'h20, 1, 0, 32'h10, 0, 2'b11, 2'b10));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, F, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11));
    repeat (3) @(posedge CLK);
    #1;
    chk("reset ramREN", 32'(ramREN), 0);
    chk("reset ramWEN", 32'(ramWEN), 0);
    chk("reset ramaddr", ramaddr, 0);
    chk("reset ramstore", ramstore, 0);
    chk("reset iwait", 32'(iwait), 32'h3);
    chk("reset dwait", 32'(dwait), 32'h3);
    nRST = 1'b1;
    foreach (tbl[r]) step(r, tbl[r]);
    // reset while a write is in flight
    dWEN = 2'b01; ramstate = F;
    @(posedge CLK); #1;
    chk("midwr ramWEN", 32'(ramWEN), 1);
    chk("midwr ramstore", ramstore, 32'h5555);
    nRST = 1'b0; ramstate = B;
    @(posedge CLK); #1;
    ramstate = A;
    #1;
    chk("rst ramWEN", 32'(ramWEN), 0);
    chk("rst ramREN", 32'(ramREN), 0);
    chk("rst ramaddr", ramaddr, 0);
    chk("rst ramstore", ramstore, 0);
    chk("rst dwait", 32'(dwait), 32'h3);
    chk("rst iwait", 32'(iwait), 32'h3);
    dWEN = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    // randomized traffic: cores hold requests until released
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int c = 0; c < CPUS; c++) begin dpend[c] = 0; ipend[c] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!dpend[c] && $urandom_range(0, 3) == 0) begin
          dpend[c] = 1; dwr[c] = 1'($urandom_range(0, 1)); dboth[c] = 1'($urandom_range(0, 1));
          dad[c] = {26'b0, 4'($urandom_range(0, 15)), 2'b00}; dst[c] = $urandom;
        end
        if (!ipend[c] && $urandom_range(0, 3) == 0) begin
          ipend[c] = 1; iad[c] = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
        end
        dREN[c] = dpend[c] && (!dwr[c] || dboth[c]);
        dWEN[c] = dpend[c] && dwr[c];
        iREN[c] = ipend[c];
        daddr[c] = dad[c]; dstore[c] = dst[c]; iaddr[c] = iad[c];
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload = act ? mem[ma[5:2]] : $urandom;
      #1;
      rel = act && ramstate == A;
      iwx = '1; dwx = '1;
      if (rel && isd) dwx[own] = 1'b0;
      if (rel && !isd) iwx[own] = 1'b0;
      chk("rnd ramREN", 32'(ramREN), 32'(act && !(isd && isw)));
      chk("rnd ramWEN", 32'(ramWEN), 32'(act && isd && isw));
      chk("rnd iwait", 32'(iwait), 32'(iwx));
      chk("rnd dwait", 32'(dwait), 32'(dwx));
      if (act) chk("rnd ramaddr", ramaddr, ma);
      if (act && isd && isw) chk("rnd ramstore", ramstore, ms);
      if (rel) chk("rnd load", isd ? dload[own] : iload[own], mem[ma[5:2]]);
      model_edge();
      @(posedge CLK); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
